matrix_axis_frame_loader: RTL and testbench
===========================================

Name: matrix_axis_frame_loader

Overview:
- Successor to the single-panel LED matrix controller front end. Accepts row-update and buffer-swap packets on an AXI-Stream slave (MAC RX FIFO output) at parametrised bus width.
- Unpacks RGB888 pixels into a double-banked framebuffer write port covering PANELS x ROWS x COLS pixels.
- Hands banks to the scan engine only at display frame boundaries, so a partially written frame is never shown.

Parameters:
- AXIS_DATA_WIDTH, 8, stream width; multiple of 8, max 64.
- AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- PANELS, 1, number of chained panels.
- ROWS, 32, rows per panel.
- COLS, 64, pixels per row.
- PIX_ADDR_W, $clog2(PANELS*ROWS*COLS), pixel address width excluding bank bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  AXIS_DATA_WIDTH  packet bytes; lane 0 first.
- s_axis_tkeep  in  AXIS_KEEP_WIDTH  valid lanes; contiguous from lane 0; only the last beat may be partial.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tuser  in  1  bad-frame flag, sampled with tlast.
- fb_wr_en  out  1  framebuffer write strobe.
- fb_wr_addr  out  PIX_ADDR_W+1  {bank, pixel index}.
- fb_wr_data  out  24  pixel {R,G,B}.
- disp_frame_done  in  1  single-cycle pulse from the scan engine at end of frame.
- disp_bank  out  1  bank the scan engine reads.
- swap_pending  out  1  swap requested, not yet applied.
- stat_rows_ok  out  16  rows completed without error; saturating.
- stat_errors  out  16  packets in error; saturating.

Behaviour:
- Reset:
  - All outputs 0, so writes target bank 1.
  - FSM to CMD; lane index 0; pixel byte counter 0.
  - Reset mid-packet: remaining beats are parsed as a new packet. The resulting error is counted.
- Byte engine: one byte is processed per clk.
  - A beat is held while its lanes 0..n-1 (n = popcount(tkeep)) are consumed in order.
  - s_axis_tready=1 only in the cycle the last valid lane is processed. A beat of AXIS_KEEP_WIDTH lanes therefore takes AXIS_KEEP_WIDTH cycles.
  - With AXIS_DATA_WIDTH=8, tready=1 every cycle the FSM is consuming.
  - A byte is "last" when it is the last valid lane and tlast=1.
- FSM states:
  - CMD: byte 0x01 -> PANEL. Byte 0x02 -> SWAP_CHK. Any other byte -> error, DISCARD.
  - SWAP_CHK: the command byte must be last with tuser=0. If so, set swap_pending; otherwise error. Return to CMD, or go to DISCARD if not last.
  - PANEL: latch the byte. If >=PANELS -> error, DISCARD. Otherwise -> ROW.
  - ROW: latch the byte. If >=ROWS -> error, DISCARD. Otherwise col=0, byte phase=0, go to PIXEL.
  - PIXEL: collect R, G, B.
    - On B: fb_wr_en=1 on the next clk, with addr={~disp_bank,(panel*ROWS+row)*COLS+col} and data {R,G,B}; col increments.
    - After the COLS-th pixel the byte must be last. If tuser=0, stat_rows_ok++ and go to CMD.
    - If tuser=1: error, go to CMD. Pixels already written remain (back bank only).
    - Last byte earlier than pixel COLS (short row): error, go to CMD. Any partial R/G is dropped.
    - Not last after the final pixel (long row): error, go to DISCARD.
  - DISCARD: consume bytes until a last byte, then go to CMD. No further error is counted.
- Error accounting: at most one error per packet; both counters saturate at 0xFFFF.
- Swap:
  - When swap_pending=1 and disp_frame_done=1: disp_bank toggles and swap_pending clears in the same clk.
  - A swap command while already pending is absorbed, giving a single swap.
  - Swap accepted in the same clk as disp_frame_done: pending sets; the toggle waits for the next disp_frame_done.
  - Write address uses the disp_bank value at write issue. Writes in flight at the swap cycle go to the old back bank.
- Write latency: 1 clk from acceptance of the B byte. fb_wr_en is never back-to-back more than once per 3 clks.

Decomposition:
- Package matrix_pkg:
  - command constants CMD_ROW_WRITE=8'h01 and CMD_SWAP=8'h02;
  - FSM state enum;
  - pixel struct {r,g,b}.
- One sub-module, matrix_axis_byte_serializer: performs the beat-to-byte lane walk. It outputs byte, byte_valid, byte_last, byte_user, and accepts byte_ready.

Test Plan (PANELS=2, ROWS=4, COLS=4, width 8 and 32):
- Reset, then row packet 01 01 02 + 12 bytes 11 22 33... -> 4 writes at addr 56..59 (bank 1, index 24..27), data 0x112233...; stat_rows_ok=1; disp_bank=0.
- Packet 02 (tlast) then disp_frame_done pulse -> swap_pending=1 until the pulse, then disp_bank=1 and pending=0. Next row write targets bank 0 (addr 24..27).
- 32-bit bus, same row packet packed with last beat tkeep=4'b0111 -> identical writes; tready high once per 4 clks.
- Row packet with panel=2 -> no writes, stat_errors=1. Next valid packet is parsed normally.
- Short row (tlast after 2 pixels + 1 byte) -> 2 writes, stat_errors=1. Long row (extra byte) -> 4 writes, stat_errors++, discard to tlast.
- Swap command and disp_frame_done in the same clk -> no toggle; toggles on the following pulse. Two swap commands before a pulse -> a single toggle.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and types for the LED matrix AXI-Stream frame loader.
package matrix_pkg;

    localparam logic [7:0] CMD_ROW_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP      = 8'h02;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_SWAP_CHK,
        ST_PANEL,
        ST_ROW,
        ST_PIXEL,
        ST_DISCARD
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/matrix_axis_byte_serializer.sv
// Walks the valid lanes of each AXI-Stream beat, presenting one byte per
// accepted cycle; the beat is only acknowledged on its last valid lane.
module matrix_axis_byte_serializer #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic [KEEP_W-1:0] s_tkeep,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic              s_tuser,
    output logic [7:0]        byte_data,
    output logic              byte_valid,
    output logic              byte_last,
    output logic              byte_user,
    input  logic              byte_ready
);

    localparam int LANE_W = (KEEP_W > 1) ? $clog2(KEEP_W) : 1;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LANE_W:0]   n_lanes;
    logic [LANE_W:0]   lane_p1;
    logic              last_lane;
    logic [7:0]        lane_bytes [KEEP_W];

    genvar gi;
    generate
        for (gi = 0; gi < KEEP_W; gi++) begin : g_lane
            assign lane_bytes[gi] = s_tdata[gi*8 +: 8];
        end
    endgenerate

    // tkeep is contiguous from lane 0, so its popcount is the lane count.
    always_comb begin
        n_lanes = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n_lanes = n_lanes + {{LANE_W{1'b0}}, s_tkeep[i]};
        end
    end

    always_comb begin
        byte_data = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (lane_q == LANE_W'(i)) begin
                byte_data = lane_bytes[i];
            end
        end
    end

    assign lane_p1    = {1'b0, lane_q} + {{LANE_W{1'b0}}, 1'b1};
    assign last_lane  = (lane_p1 >= n_lanes);
    assign byte_valid = s_tvalid;
    assign byte_last  = last_lane & s_tlast;
    assign byte_user  = s_tuser;
    assign s_tready   = s_tvalid & byte_ready & last_lane;
    assign lane_d     = last_lane ? '0 : lane_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else if (s_tvalid && byte_ready) begin
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/matrix_axis_frame_loader.sv
// Parses row-write / buffer-swap packets into a double-banked framebuffer and
// hands the freshly written bank to the scan engine only at frame boundaries.
module matrix_axis_frame_loader
    import matrix_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 8,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int PANELS          = 1,
    parameter int ROWS            = 32,
    parameter int COLS            = 64,
    parameter int PIX_ADDR_W      = $clog2(PANELS * ROWS * COLS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    input  logic                       s_axis_tuser,
    output logic                       fb_wr_en,
    output logic [PIX_ADDR_W:0]        fb_wr_addr,
    output logic [23:0]                fb_wr_data,
    input  logic                       disp_frame_done,
    output logic                       disp_bank,
    output logic                       swap_pending,
    output logic [15:0]                stat_rows_ok,
    output logic [15:0]                stat_errors
);

    localparam int COL_W = $clog2(COLS + 1);

    state_e            state_q, state_d;
    logic [7:0]        byte_data;
    logic              byte_valid, byte_last, byte_user, byte_ready, byte_fire;
    logic [7:0]        panel_q, panel_d, row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [1:0]        phase_q, phase_d;
    logic [7:0]        r_q, r_d, g_q, g_d;
    logic              chk_last_q, chk_last_d, chk_user_q, chk_user_d;
    logic              wr_en_q, wr_en_d;
    logic [PIX_ADDR_W:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_pix_q, wr_pix_d;
    logic              bank_q, bank_d, pend_q, pend_d;
    logic [15:0]       rows_ok_q, rows_ok_d, errors_q, errors_d;
    logic              err_evt, ok_evt, swap_set;
    logic [PIX_ADDR_W-1:0] pix_idx;

    matrix_axis_byte_serializer #(
        .DATA_W (AXIS_DATA_WIDTH),
        .KEEP_W (AXIS_KEEP_WIDTH)
    ) u_serializer (
        .clk        (clk),
        .rst        (rst),
        .s_tdata    (s_axis_tdata),
        .s_tkeep    (s_axis_tkeep),
        .s_tvalid   (s_axis_tvalid),
        .s_tready   (s_axis_tready),
        .s_tlast    (s_axis_tlast),
        .s_tuser    (s_axis_tuser),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_user  (byte_user),
        .byte_ready (byte_ready)
    );

    // The swap check evaluates the latched command byte without consuming input.
    assign byte_ready = ~rst & (state_q != ST_SWAP_CHK);
    assign byte_fire  = byte_valid & byte_ready;
    assign pix_idx    = PIX_ADDR_W'((32'(panel_q) * ROWS + 32'(row_q)) * COLS + 32'(col_q));

    always_comb begin
        state_d    = state_q;
        panel_d    = panel_q;
        row_d      = row_q;
        col_d      = col_q;
        phase_d    = phase_q;
        r_d        = r_q;
        g_d        = g_q;
        chk_last_d = chk_last_q;
        chk_user_d = chk_user_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_pix_d   = wr_pix_q;
        err_evt    = 1'b0;
        ok_evt     = 1'b0;
        swap_set   = 1'b0;
        case (state_q)
            ST_CMD: begin
                if (byte_fire) begin
                    if (byte_data == CMD_SWAP) begin
                        chk_last_d = byte_last;
                        chk_user_d = byte_user;
                        state_d    = ST_SWAP_CHK;
                    end else if (byte_data == CMD_ROW_WRITE && !byte_last) begin
                        state_d = ST_PANEL;
                    end else begin
                        err_evt = 1'b1;
                        state_d = byte_last ? ST_CMD : ST_DISCARD;
                    end
                end
            end
            ST_SWAP_CHK: begin
                if (chk_last_q && !chk_user_q) begin
                    swap_set = 1'b1;
                end else begin
                    err_evt = 1'b1;
                end
                state_d = chk_last_q ? ST_CMD : ST_DISCARD;
            end
            ST_PANEL: begin
                if (byte_fire) begin
                    panel_d = byte_data;
                    // A packet ending inside its header is truncated: error, resync at CMD.
                    if (byte_last || 32'(byte_data) >= PANELS) begin
                        err_evt = 1'b1;
                        state_d = byte_last ? ST_CMD : ST_DISCARD;
                    end else begin
                        state_d = ST_ROW;
                    end
                end
            end
            ST_ROW: begin
                if (byte_fire) begin
                    row_d = byte_data;
                    if (byte_last || 32'(byte_data) >= ROWS) begin
                        err_evt = 1'b1;
                        state_d = byte_last ? ST_CMD : ST_DISCARD;
                    end else begin
                        col_d   = '0;
                        phase_d = 2'd0;
                        state_d = ST_PIXEL;
                    end
                end
            end
            ST_PIXEL: begin
                if (byte_fire) begin
                    case (phase_q)
                        2'd0: begin
                            r_d     = byte_data;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            g_d     = byte_data;
                            phase_d = 2'd2;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {~bank_q, pix_idx};
                            wr_pix_d  = '{r: r_q, g: g_q, b: byte_data};
                            col_d     = col_q + 1'b1;
                            phase_d   = 2'd0;
                        end
                    endcase
                    if (phase_q == 2'd2 && 32'(col_q) == COLS - 1) begin
                        if (!byte_last) begin
                            err_evt = 1'b1;
                            state_d = ST_DISCARD;
                        end else begin
                            err_evt = byte_user;
                            ok_evt  = ~byte_user;
                            state_d = ST_CMD;
                        end
                    end else if (byte_last) begin
                        err_evt = 1'b1;
                        state_d = ST_CMD;
                    end
                end
            end
            ST_DISCARD: begin
                if (byte_fire && byte_last) begin
                    state_d = ST_CMD;
                end
            end
            default: state_d = ST_CMD;
        endcase
    end

    always_comb begin
        rows_ok_d = (ok_evt && rows_ok_q != 16'hFFFF) ? rows_ok_q + 16'd1 : rows_ok_q;
        errors_d  = (err_evt && errors_q != 16'hFFFF) ? errors_q + 16'd1 : errors_q;
        bank_d    = bank_q ^ (pend_q & disp_frame_done);
        // A swap landing in the frame-done cycle stays pending for the next frame.
        pend_d    = swap_set | (pend_q & ~disp_frame_done);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CMD;
            panel_q    <= '0;
            row_q      <= '0;
            col_q      <= '0;
            phase_q    <= '0;
            r_q        <= '0;
            g_q        <= '0;
            chk_last_q <= 1'b0;
            chk_user_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_pix_q   <= '0;
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            rows_ok_q  <= '0;
            errors_q   <= '0;
        end else begin
            state_q    <= state_d;
            panel_q    <= panel_d;
            row_q      <= row_d;
            col_q      <= col_d;
            phase_q    <= phase_d;
            r_q        <= r_d;
            g_q        <= g_d;
            chk_last_q <= chk_last_d;
            chk_user_q <= chk_user_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_pix_q   <= wr_pix_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            rows_ok_q  <= rows_ok_d;
            errors_q   <= errors_d;
        end
    end

    assign fb_wr_en     = wr_en_q;
    assign fb_wr_addr   = wr_addr_q;
    assign fb_wr_data   = wr_pix_q;
    assign disp_bank    = bank_q;
    assign swap_pending = pend_q;
    assign stat_rows_ok = rows_ok_q;
    assign stat_errors  = errors_q;

endmodule

// File: tb/tb_matrix_axis_frame_loader.sv
// Drives an 8-bit and a 32-bit loader with identical packet streams and checks
// writes, counters and bank handling against a packet-level reference model.
module tb_matrix_axis_frame_loader;

    localparam int P  = 2;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 6;

    typedef logic [7:0]  bq_t[$];
    typedef logic [29:0] wq_t[$];

    typedef struct {
        logic [7:0] cmd;
        int         panel;
        int         row;
        int         npb;
        bit         user;
        int         exp_w;
        int         exp_ok;
        int         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]    a_tdata = '0;
    logic          a_tkeep = '0, a_tvalid = 1'b0, a_tlast = 1'b0, a_tuser = 1'b0, a_fd = 1'b0;
    logic          a_tready, a_wen, a_bank, a_pend;
    logic [AW-1:0] a_waddr;
    logic [23:0]   a_wdata;
    logic [15:0]   a_ok, a_err;

    logic [31:0]   b_tdata = '0;
    logic [3:0]    b_tkeep = '0;
    logic          b_tvalid = 1'b0, b_tlast = 1'b0, b_tuser = 1'b0, b_fd = 1'b0;
    logic          b_tready, b_wen, b_bank, b_pend;
    logic [AW-1:0] b_waddr;
    logic [23:0]   b_wdata;
    logic [15:0]   b_ok, b_err;

    matrix_axis_frame_loader #(.AXIS_DATA_WIDTH(8), .PANELS(P), .ROWS(R), .COLS(C)) dut8 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
        .s_axis_tready(a_tready), .s_axis_tlast(a_tlast), .s_axis_tuser(a_tuser),
        .fb_wr_en(a_wen), .fb_wr_addr(a_waddr), .fb_wr_data(a_wdata),
        .disp_frame_done(a_fd), .disp_bank(a_bank), .swap_pending(a_pend),
        .stat_rows_ok(a_ok), .stat_errors(a_err)
    );

    matrix_axis_frame_loader #(.AXIS_DATA_WIDTH(32), .PANELS(P), .ROWS(R), .COLS(C)) dut32 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
        .s_axis_tready(b_tready), .s_axis_tlast(b_tlast), .s_axis_tuser(b_tuser),
        .fb_wr_en(b_wen), .fb_wr_addr(b_waddr), .fb_wr_data(b_wdata),
        .disp_frame_done(b_fd), .disp_bank(b_bank), .swap_pending(b_pend),
        .stat_rows_ok(b_ok), .stat_errors(b_err)
    );

    // Write logs, one writer each.
    logic [29:0] wlog_a [1024];
    logic [29:0] wlog_b [1024];
    int wn_a = 0;
    int wn_b = 0;
    always @(negedge clk) if (a_wen) begin wlog_a[wn_a % 1024] <= {a_waddr, a_wdata}; wn_a <= wn_a + 1; end
    always @(negedge clk) if (b_wen) begin wlog_b[wn_b % 1024] <= {b_waddr, b_wdata}; wn_b <= wn_b + 1; end

    int tests = 0;
    int fails = 0;
    int rd [2];
    int m_ok [2];
    int m_err [2];
    bit m_bank [2];
    bit m_pend [2];
    vec_t tbl [10];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] f_ok(int d);  return d == 0 ? a_ok : b_ok;     endfunction
    function automatic logic [15:0] f_err(int d); return d == 0 ? a_err : b_err;   endfunction
    function automatic logic f_bank(int d);       return d == 0 ? a_bank : b_bank; endfunction
    function automatic logic f_pend(int d);       return d == 0 ? a_pend : b_pend; endfunction
    function automatic int f_wn(int d);           return d == 0 ? wn_a : wn_b;     endfunction
    function automatic logic [29:0] wget(int d, int idx);
        return d == 0 ? wlog_a[idx % 1024] : wlog_b[idx % 1024];
    endfunction

    function automatic bq_t mk_pkt(logic [7:0] cmd, int panel, int row, int npb, bit rnd);
        bq_t q;
        q.push_back(cmd);
        if (cmd == 8'h01) begin
            q.push_back(8'(panel));
            q.push_back(8'(row));
        end
        for (int k = 0; k < npb; k++) q.push_back(rnd ? 8'($urandom) : 8'(17 * (k + 1)));
        return q;
    endfunction

    // Packet-level reference: what a whole packet should write and count.
    task automatic model_pkt(int d, bq_t p, bit user, output wq_t w);
        int n = p.size();
        w = {};
        if (p[0] == 8'h02) begin
            if (n == 1 && !user) m_pend[d] = 1'b1;
            else m_err[d]++;
        end else if (p[0] == 8'h01 && n >= 3) begin
            if (int'(p[1]) >= P || int'(p[2]) >= R) begin
                m_err[d]++;
            end else begin
                int npx = (n - 3) / 3;
                if (npx > C) npx = C;
                for (int k = 0; k < npx; k++) begin
                    int addr = (m_bank[d] ? 0 : 32) + (int'(p[1]) * R + int'(p[2])) * C + k;
                    w.push_back({6'(addr), p[3 + 3*k], p[4 + 3*k], p[5 + 3*k]});
                end
                if (n == 3 + 3 * C && !user) m_ok[d]++;
                else m_err[d]++;
            end
        end else begin
            m_err[d]++;
        end
    endtask

    task automatic drive(int d, logic [31:0] data, logic [3:0] keep, logic v, logic l, logic u);
        if (d == 0) begin
            a_tdata = data[7:0]; a_tkeep = keep[0]; a_tvalid = v; a_tlast = l; a_tuser = u;
        end else begin
            b_tdata = data; b_tkeep = keep; b_tvalid = v; b_tlast = l; b_tuser = u;
        end
    endtask

    task automatic send(int d, bq_t p, bit user, bit end_last);
        int lanes = (d == 0) ? 1 : 4;
        int i = 0;
        while (i < p.size()) begin
            int n = p.size() - i;
            int cyc = 0;
            bit rdy = 1'b0;
            logic [31:0] data = '0;
            logic [3:0] keep = '0;
            if (n > lanes) n = lanes;
            for (int k = 0; k < n; k++) begin
                data[8*k +: 8] = p[i + k];
                keep[k] = 1'b1;
            end
            drive(d, data, keep, 1'b1, end_last && (i + n == p.size()), user);
            do begin
                @(negedge clk);
                rdy = (d == 0) ? a_tready : b_tready;
                cyc++;
                @(posedge clk); #1;
            end while (!rdy && cyc < 40);
            check($sformatf("handshake d%0d", d), 64'(rdy), 64'd1);
            if (!rdy) break;
            // One byte per clock: a beat is acknowledged after exactly its lane count.
            if (p[0] != 8'h02) check($sformatf("beat_cycles d%0d", d), 64'(cyc), 64'(n));
            i += n;
        end
        drive(d, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_pkt(int d, bq_t p, bit user, string tag, output int nw, output int dok, output int derr);
        wq_t exp;
        int ok0 = int'(f_ok(d));
        int err0 = int'(f_err(d));
        int got;
        model_pkt(d, p, user, exp);
        send(d, p, user, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        got = f_wn(d) - rd[d];
        check({tag, " writes"}, 64'(got), 64'(exp.size()));
        for (int k = 0; k < exp.size() && k < got; k++)
            check($sformatf("%s wr%0d", tag, k), 64'(wget(d, rd[d] + k)), 64'(exp[k]));
        rd[d] += got;
        check({tag, " rows_ok"}, 64'(f_ok(d)), 64'(m_ok[d]));
        check({tag, " errors"}, 64'(f_err(d)), 64'(m_err[d]));
        check({tag, " bank"}, 64'(f_bank(d)), 64'(m_bank[d]));
        check({tag, " pending"}, 64'(f_pend(d)), 64'(m_pend[d]));
        nw = got;
        dok = int'(f_ok(d)) - ok0;
        derr = int'(f_err(d)) - err0;
    endtask

    task automatic pulse(int d);
        if (d == 0) a_fd = 1'b1; else b_fd = 1'b1;
        if (m_pend[d]) begin
            m_bank[d] = ~m_bank[d];
            m_pend[d] = 1'b0;
        end
        @(posedge clk); #1;
        if (d == 0) a_fd = 1'b0; else b_fd = 1'b0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ok[d] = 0; m_err[d] = 0; m_bank[d] = 1'b0; m_pend[d] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int nw, dok, derr;
        bq_t pk;
        tbl[0] = '{8'h01, 1, 2, 12, 1'b0, 4, 1, 0};
        tbl[1] = '{8'h01, 2, 0, 12, 1'b0, 0, 0, 1};
        tbl[2] = '{8'h01, 0, 4, 12, 1'b0, 0, 0, 1};
        tbl[3] = '{8'h01, 0, 0, 7,  1'b0, 2, 0, 1};
        tbl[4] = '{8'h01, 1, 3, 13, 1'b0, 4, 0, 1};
        tbl[5] = '{8'h01, 0, 1, 12, 1'b1, 4, 0, 1};
        tbl[6] = '{8'h05, 0, 0, 3,  1'b0, 0, 0, 1};
        tbl[7] = '{8'h02, 0, 0, 1,  1'b0, 0, 0, 1};
        tbl[8] = '{8'h02, 0, 0, 0,  1'b1, 0, 0, 1};
        tbl[9] = '{8'h01, 0, 3, 12, 1'b0, 4, 1, 0};

        model_reset();
        rd[0] = 0; rd[1] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset tready d%0d", d), 64'(d == 0 ? a_tready : b_tready), 64'd0);
            check($sformatf("reset wr_en d%0d", d), 64'(d == 0 ? a_wen : b_wen), 64'd0);
            check($sformatf("reset wr_addr d%0d", d), 64'(d == 0 ? a_waddr : b_waddr), 64'd0);
            check($sformatf("reset wr_data d%0d", d), 64'(d == 0 ? a_wdata : b_wdata), 64'd0);
            check($sformatf("reset bank d%0d", d), 64'(f_bank(d)), 64'd0);
            check($sformatf("reset pending d%0d", d), 64'(f_pend(d)), 64'd0);
            check($sformatf("reset rows_ok d%0d", d), 64'(f_ok(d)), 64'd0);
            check($sformatf("reset errors d%0d", d), 64'(f_err(d)), 64'd0);
        end

        // Reset mid-packet: the remainder is parsed as a fresh (bad) packet.
        @(posedge clk); #1;
        pk = '{8'h01, 8'h01};
        send(0, pk, 1'b0, 1'b0);
        send(1, pk, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        pk = '{8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int d = 0; d < 2; d++) begin
            run_pkt(d, pk, 1'b0, $sformatf("midrst d%0d", d), nw, dok, derr);
            check($sformatf("midrst errdelta d%0d", d), 64'(derr), 64'd1);
        end

        // Table-driven vectors against both bus widths.
        for (int t = 0; t < 10; t++) begin
            for (int d = 0; d < 2; d++) begin
                string tag = $sformatf("vec%0d d%0d", t, d);
                pk = mk_pkt(tbl[t].cmd, tbl[t].panel, tbl[t].row, tbl[t].npb, 1'b0);
                run_pkt(d, pk, tbl[t].user, tag, nw, dok, derr);
                check({tag, " n_writes"}, 64'(nw), 64'(tbl[t].exp_w));
                check({tag, " ok_delta"}, 64'(dok), 64'(tbl[t].exp_ok));
                check({tag, " err_delta"}, 64'(derr), 64'(tbl[t].exp_err));
                if (t == 0 && nw == 4) begin
                    check({tag, " first addr"}, 64'(wget(d, rd[d] - 4)), {34'd0, 6'd56, 24'h112233});
                    check({tag, " last addr"}, 64'(wget(d, rd[d] - 1)), {34'd0, 6'd59, 24'hAABBCC});
                end
            end
        end

        // Swap sequences.
        for (int d = 0; d < 2; d++) begin
            string tag = $sformatf("swap d%0d", d);
            run_pkt(d, '{8'h02}, 1'b0, {tag, " cmd"}, nw, dok, derr);
            repeat (3) @(posedge clk);
            #1 check({tag, " still pending"}, 64'(f_pend(d)), 64'd1);
            pulse(d);
            check({tag, " toggled bank"}, 64'(f_bank(d)), 64'd1);
            check({tag, " cleared"}, 64'(f_pend(d)), 64'd0);
            pk = mk_pkt(8'h01, 1, 2, 12, 1'b0);
            run_pkt(d, pk, 1'b0, {tag, " row"}, nw, dok, derr);
            if (nw == 4) check({tag, " bank0 addr"}, 64'(wget(d, rd[d] - 4) >> 24), 64'd24);

            // Frame-done arriving in the cycle the swap is accepted.
            send(d, '{8'h02}, 1'b0, 1'b1);
            if (d == 0) a_fd = 1'b1; else b_fd = 1'b1;
            @(posedge clk); #1;
            if (d == 0) a_fd = 1'b0; else b_fd = 1'b0;
            @(negedge clk);
            check({tag, " same-clk bank"}, 64'(f_bank(d)), 64'd1);
            check({tag, " same-clk pend"}, 64'(f_pend(d)), 64'd1);
            m_pend[d] = 1'b1;
            @(posedge clk); #1;
            pulse(d);
            check({tag, " next pulse bank"}, 64'(f_bank(d)), 64'd0);

            run_pkt(d, '{8'h02}, 1'b0, {tag, " dbl1"}, nw, dok, derr);
            run_pkt(d, '{8'h02}, 1'b0, {tag, " dbl2"}, nw, dok, derr);
            pulse(d);
            check({tag, " dbl bank"}, 64'(f_bank(d)), 64'd1);
            pulse(d);
            check({tag, " dbl single"}, 64'(f_bank(d)), 64'd1);
            check({tag, " dbl pend"}, 64'(f_pend(d)), 64'd0);
        end

        // Randomized packet stream, identical on both widths.
        for (int it = 0; it < 40; it++) begin
            int r = $urandom_range(0, 9);
            int panel = (r == 0) ? $urandom_range(2, 255) : $urandom_range(0, P - 1);
            int row = (r == 1) ? $urandom_range(4, 255) : $urandom_range(0, R - 1);
            int npb = (r == 2) ? $urandom_range(0, 11) : (r == 3) ? $urandom_range(13, 15) : 12;
            bit user = (r == 4);
            bit do_pulse = ($urandom_range(0, 3) == 0);
            if (r == 5) pk = '{8'h02};
            else if (r == 6) pk = mk_pkt(8'($urandom_range(3, 255)), 0, 0, $urandom_range(0, 4), 1'b1);
            else pk = mk_pkt(8'h01, panel, row, npb, 1'b1);
            for (int d = 0; d < 2; d++) begin
                run_pkt(d, pk, user, $sformatf("rnd%0d d%0d", it, d), nw, dok, derr);
                if (do_pulse) begin
                    pulse(d);
                    check($sformatf("rnd%0d pulse bank d%0d", it, d), 64'(f_bank(d)), 64'(m_bank[d]));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
